// File: rtl/i8080_pkg.sv
// Shared 8080 fetch/decode constants: FSM state codes, instruction length codes,
// opcode match patterns and the assembled-instruction record.
package i8080_pkg;

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_B2    = 3'd2;
  localparam logic [2:0] S_B3    = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [7:0] OP_HLT = 8'h76;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Families: mask out the register-pair (rp) or condition/register (ccc/ddd) field.
  localparam logic [7:0] MASK_RP     = 8'hCF;
  localparam logic [7:0] MASK_CCC    = 8'hC7;
  localparam logic [7:0] PAT_LXI     = 8'h01;
  localparam logic [7:0] PAT_JCCC    = 8'hC2;
  localparam logic [7:0] PAT_CCCC    = 8'hC4;
  localparam logic [7:0] PAT_MVI     = 8'h06;
  localparam logic [7:0] PAT_ALU_IMM = 8'hC6;

  localparam logic [7:0] OP_SHLD = 8'h22;
  localparam logic [7:0] OP_LHLD = 8'h2A;
  localparam logic [7:0] OP_STA  = 8'h32;
  localparam logic [7:0] OP_LDA  = 8'h3A;
  localparam logic [7:0] OP_JMP  = 8'hC3;
  localparam logic [7:0] OP_CALL = 8'hCD;
  localparam logic [7:0] OP_OUT  = 8'hD3;
  localparam logic [7:0] OP_IN   = 8'hDB;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } ins_t;

endpackage

// File: rtl/i8080_fetch_seq_if.sv
// Program-memory bus, instruction handshake and flow-control signals of the fetch sequencer.
interface i8080_fetch_seq_if;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_opcode;
  logic [15:0] ins_imm;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        resume;
  logic        halted;

  modport master (
    output mem_rd_en, mem_addr, ins_valid, ins_opcode, ins_imm, ins_len, ins_pc, halted,
    input  mem_rdata, ins_ready, redirect, redirect_pc, resume
  );

  modport slave (
    input  mem_rd_en, mem_addr, ins_valid, ins_opcode, ins_imm, ins_len, ins_pc, halted,
    output mem_rdata, ins_ready, redirect, redirect_pc, resume
  );
endinterface

// File: rtl/i8080_ins_len.sv
// Combinational 8080 opcode -> instruction length (1..3 bytes); undocumented opcodes are 1 byte.
module i8080_ins_len
  import i8080_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb begin
    len = LEN_1;
    if (((opcode & MASK_RP) == PAT_LXI) ||
        ((opcode & MASK_CCC) == PAT_JCCC) ||
        ((opcode & MASK_CCC) == PAT_CCCC) ||
        (opcode == OP_SHLD) || (opcode == OP_LHLD) ||
        (opcode == OP_STA)  || (opcode == OP_LDA)  ||
        (opcode == OP_JMP)  || (opcode == OP_CALL)) begin
      len = LEN_3;
    end else if (((opcode & MASK_CCC) == PAT_MVI) ||
                 ((opcode & MASK_CCC) == PAT_ALU_IMM) ||
                 (opcode == OP_OUT) || (opcode == OP_IN)) begin
      len = LEN_2;
    end
  end

endmodule

// File: rtl/i8080_fetch_seq.sv
// 8080 instruction fetch sequencer: owns the PC, reads opcode plus operands from
// synchronous byte memory and offers one assembled instruction per valid/ready handshake.
module i8080_fetch_seq
  import i8080_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [7:0]  HLT_OPCODE = OP_HLT
) (
  input  logic              clk,
  input  logic              rst_n,
  i8080_fetch_seq_if.master bus
);

  logic [2:0]  state_q;
  logic [15:0] pc_q;
  ins_t        ins_q;
  logic [1:0]  op_len;

  i8080_ins_len u_ins_len (
    .opcode (bus.mem_rdata),
    .len    (op_len)
  );

  // Operand reads are issued in the same cycle the previous byte arrives.
  // A redirect suppresses the read since its data would be discarded anyway.
  always_comb begin
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = pc_q;
    if (rst_n && !bus.redirect) begin
      case (state_q)
        S_REQ: begin
          bus.mem_rd_en = 1'b1;
          bus.mem_addr  = pc_q;
        end
        S_OP: begin
          if (op_len != LEN_1) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = pc_q + 16'd1;
          end
        end
        S_B2: begin
          if (ins_q.len == LEN_3) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = pc_q + 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
    end else if (bus.redirect) begin
      state_q <= S_REQ;
      pc_q    <= bus.redirect_pc;
    end else begin
      case (state_q)
        S_REQ: state_q <= S_OP;
        S_OP: begin
          ins_q.opcode <= bus.mem_rdata;
          ins_q.pc     <= pc_q;
          ins_q.len    <= op_len;
          ins_q.imm    <= '0;
          state_q      <= (op_len == LEN_1) ? S_ISSUE : S_B2;
        end
        S_B2: begin
          ins_q.imm <= {8'h00, bus.mem_rdata};
          state_q   <= (ins_q.len == LEN_3) ? S_B3 : S_ISSUE;
        end
        S_B3: begin
          ins_q.imm[15:8] <= bus.mem_rdata;
          state_q         <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.ins_ready) begin
            pc_q    <= ins_q.pc + {14'd0, ins_q.len};
            state_q <= (ins_q.opcode == HLT_OPCODE) ? S_HALT : S_REQ;
          end
        end
        S_HALT: begin
          if (bus.resume) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.ins_valid  = (state_q == S_ISSUE);
  assign bus.halted     = (state_q == S_HALT);
  assign bus.ins_opcode = ins_q.opcode;
  assign bus.ins_imm    = ins_q.imm;
  assign bus.ins_len    = ins_q.len;
  assign bus.ins_pc     = ins_q.pc;

endmodule

// File: tb/tb_i8080_fetch_seq.sv
// Bench for i8080_fetch_seq: directed scenarios plus a random program checked
// against a table-driven instruction-stream model.
module tb_i8080_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n_b;
  int   checks = 0;
  int   errors = 0;
  int   len_tbl [256];
  logic [7:0] mem [0:65535];

  i8080_fetch_seq_if a ();
  i8080_fetch_seq_if b ();

  i8080_fetch_seq #(.RESET_PC(16'h0000), .HLT_OPCODE(8'h76)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.master));
  i8080_fetch_seq #(.RESET_PC(16'h0100), .HLT_OPCODE(8'h76)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(b.master));

  // Synchronous program memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (a.mem_rd_en) a.mem_rdata <= mem[a.mem_addr];
    if (b.mem_rd_en) b.mem_rdata <= mem[b.mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic build_len_tbl();
    for (int i = 0; i < 256; i++) len_tbl[i] = 1;
    for (int rp = 0; rp < 4; rp++) len_tbl[8'h01 + 16 * rp] = 3;
    for (int c = 0; c < 8; c++) begin
      len_tbl[8'hC2 + 8 * c] = 3;
      len_tbl[8'hC4 + 8 * c] = 3;
      len_tbl[8'h06 + 8 * c] = 2;
    end
    len_tbl[8'h22] = 3; len_tbl[8'h2A] = 3; len_tbl[8'h32] = 3;
    len_tbl[8'h3A] = 3; len_tbl[8'hC3] = 3; len_tbl[8'hCD] = 3;
    len_tbl[8'hC6] = 2; len_tbl[8'hCE] = 2; len_tbl[8'hD6] = 2; len_tbl[8'hDE] = 2;
    len_tbl[8'hE6] = 2; len_tbl[8'hEE] = 2; len_tbl[8'hF6] = 2; len_tbl[8'hFE] = 2;
    len_tbl[8'hD3] = 2; len_tbl[8'hDB] = 2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_a();
    a.ins_ready = 1'b0; a.redirect = 1'b0; a.redirect_pc = 16'h0; a.resume = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!a.ins_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({a.ins_valid, a.halted, a.mem_rd_en} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: valid/halted/rd_en=%b required 000",
                         {a.ins_valid, a.halted, a.mem_rd_en});
    end
    checks++;
    if ({a.ins_opcode, a.ins_imm, a.ins_len, a.ins_pc} !== 42'd0) begin
      errors++; $display("FAIL reset_fields: op=%h imm=%h len=%0d pc=%h required all zero",
                         a.ins_opcode, a.ins_imm, a.ins_len, a.ins_pc);
    end
  endtask

  task automatic test_all_zero();
    int lat;
    clear_mem();
    reset_a();
    a.ins_ready = 1'b1;
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL zero_first_read: rd_en=%b addr=%h required 1 0000", a.mem_rd_en, a.mem_addr);
    end
    wait_valid_a(lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL zero_latency: got %0d required 2", lat);
    end
    checks++;
    if (a.ins_opcode !== 8'h00 || a.ins_len !== 2'd1 || a.ins_pc !== 16'h0000 || a.ins_imm !== 16'h0000) begin
      errors++; $display("FAIL zero_insn: op=%h len=%0d pc=%h imm=%h required 00 1 0000 0000",
                         a.ins_opcode, a.ins_len, a.ins_pc, a.ins_imm);
    end
    tick();
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h0001 || a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL zero_next_fetch: rd_en=%b addr=%h valid=%b required 1 0001 0",
                         a.mem_rd_en, a.mem_addr, a.ins_valid);
    end
    a.ins_ready = 1'b0;
  endtask

  task automatic test_mvi();
    int lat;
    clear_mem();
    mem[0] = 8'h3E; mem[1] = 8'h5A;
    reset_a();
    a.ins_ready = 1'b1;
    wait_valid_a(lat);
    checks++;
    if (lat != 3 || a.ins_opcode !== 8'h3E || a.ins_imm !== 16'h005A || a.ins_len !== 2'd2) begin
      errors++; $display("FAIL mvi_insn: lat=%0d op=%h imm=%h len=%0d required 3 3E 005A 2",
                         lat, a.ins_opcode, a.ins_imm, a.ins_len);
    end
    tick();
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h0002) begin
      errors++; $display("FAIL mvi_next_fetch: rd_en=%b addr=%h required 1 0002", a.mem_rd_en, a.mem_addr);
    end
    a.ins_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
    reset_a();
    wait_valid_a(lat);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL jmp_latency: got %0d required 4", lat);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a.ins_valid !== 1'b1 || a.ins_imm !== 16'h1234 || a.ins_opcode !== 8'hC3 ||
          a.ins_len !== 2'd3 || a.mem_rd_en !== 1'b0) begin
        errors++; $display("FAIL jmp_stall_hold: valid=%b imm=%h op=%h len=%0d rd_en=%b required 1 1234 C3 3 0",
                           a.ins_valid, a.ins_imm, a.ins_opcode, a.ins_len, a.mem_rd_en);
      end
    end
    a.ins_ready = 1'b1;
    tick();
    a.ins_ready = 1'b0;
    #1;
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h0003 || a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL jmp_next_fetch: rd_en=%b addr=%h valid=%b required 1 0003 0",
                         a.mem_rd_en, a.mem_addr, a.ins_valid);
    end
  endtask

  task automatic test_redirect();
    int lat;
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'hAA; mem[2] = 8'hBB;
    reset_a();
    a.ins_ready = 1'b1;
    tick(); tick();
    a.redirect = 1'b1; a.redirect_pc = 16'h8000;
    #1;
    checks++;
    if (a.mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL redir_b2_no_read: rd_en=%b required 0", a.mem_rd_en);
    end
    tick();
    a.redirect = 1'b0;
    #1;
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h8000 || a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL redir_b2_target: rd_en=%b addr=%h valid=%b required 1 8000 0",
                         a.mem_rd_en, a.mem_addr, a.ins_valid);
    end
    wait_valid_a(lat);
    checks++;
    if (lat != 2 || a.ins_pc !== 16'h8000 || a.ins_opcode !== 8'h00) begin
      errors++; $display("FAIL redir_b2_first_insn: lat=%0d pc=%h op=%h required 2 8000 00",
                         lat, a.ins_pc, a.ins_opcode);
    end
    // Redirect coinciding with the handshake.
    mem[16'h2222] = 8'hDB; mem[16'h2223] = 8'h77;
    a.redirect = 1'b1; a.redirect_pc = 16'h2222;
    tick();
    a.redirect = 1'b0;
    #1;
    checks++;
    if (a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h2222 || a.ins_valid !== 1'b0) begin
      errors++; $display("FAIL redir_hs_target: rd_en=%b addr=%h valid=%b required 1 2222 0",
                         a.mem_rd_en, a.mem_addr, a.ins_valid);
    end
    wait_valid_a(lat);
    checks++;
    if (a.ins_pc !== 16'h2222 || a.ins_opcode !== 8'hDB || a.ins_imm !== 16'h0077) begin
      errors++; $display("FAIL redir_hs_insn: pc=%h op=%h imm=%h required 2222 DB 0077",
                         a.ins_pc, a.ins_opcode, a.ins_imm);
    end
    a.ins_ready = 1'b0;
  endtask

  task automatic test_halt();
    int lat;
    clear_mem();
    mem[16'hFFFF] = 8'h76;
    reset_a();
    a.redirect = 1'b1; a.redirect_pc = 16'hFFFF;
    tick();
    a.redirect = 1'b0;
    #1;
    wait_valid_a(lat);
    checks++;
    if (a.ins_opcode !== 8'h76 || a.ins_pc !== 16'hFFFF || a.ins_len !== 2'd1) begin
      errors++; $display("FAIL hlt_insn: op=%h pc=%h len=%0d required 76 FFFF 1",
                         a.ins_opcode, a.ins_pc, a.ins_len);
    end
    a.ins_ready = 1'b1;
    tick();
    a.ins_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a.halted !== 1'b1 || a.mem_rd_en !== 1'b0 || a.ins_valid !== 1'b0) begin
        errors++; $display("FAIL hlt_hold: cycle %0d halted=%b rd_en=%b valid=%b required 1 0 0",
                           i, a.halted, a.mem_rd_en, a.ins_valid);
      end
      tick();
    end
    a.resume = 1'b1;
    tick();
    a.resume = 1'b0;
    #1;
    checks++;
    if (a.halted !== 1'b0 || a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL hlt_resume_wrap: halted=%b rd_en=%b addr=%h required 0 1 0000",
                         a.halted, a.mem_rd_en, a.mem_addr);
    end
    // Halt again, then redirect together with resume: redirect target wins.
    a.redirect = 1'b1; a.redirect_pc = 16'hFFFF;
    tick();
    a.redirect = 1'b0;
    #1;
    wait_valid_a(lat);
    a.ins_ready = 1'b1;
    tick();
    a.ins_ready = 1'b0;
    checks++;
    if (a.halted !== 1'b1) begin
      errors++; $display("FAIL hlt_again: halted=%b required 1", a.halted);
    end
    a.resume = 1'b1; a.redirect = 1'b1; a.redirect_pc = 16'h1234;
    tick();
    a.resume = 1'b0; a.redirect = 1'b0;
    #1;
    checks++;
    if (a.halted !== 1'b0 || a.mem_rd_en !== 1'b1 || a.mem_addr !== 16'h1234) begin
      errors++; $display("FAIL hlt_redirect_wins: halted=%b rd_en=%b addr=%h required 0 1 1234",
                         a.halted, a.mem_rd_en, a.mem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    int lat;
    clear_mem();
    mem[16'h0100] = 8'h21; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    b.ins_ready = 1'b0; b.redirect = 1'b0; b.redirect_pc = 16'h0; b.resume = 1'b0;
    rst_n_b = 1'b0;
    tick();
    rst_n_b = 1'b1;
    #1;
    checks++;
    if (b.mem_rd_en !== 1'b1 || b.mem_addr !== 16'h0100) begin
      errors++; $display("FAIL rstpc_first_read: rd_en=%b addr=%h required 1 0100", b.mem_rd_en, b.mem_addr);
    end
    tick(); tick(); tick();
    rst_n_b = 1'b0;
    tick();
    checks++;
    if ({b.ins_valid, b.halted, b.mem_rd_en} !== 3'b000 ||
        {b.ins_opcode, b.ins_imm, b.ins_len, b.ins_pc} !== 42'd0) begin
      errors++; $display("FAIL rst_midfetch: valid=%b halted=%b rd_en=%b op=%h imm=%h len=%0d pc=%h required all zero",
                         b.ins_valid, b.halted, b.mem_rd_en, b.ins_opcode, b.ins_imm, b.ins_len, b.ins_pc);
    end
    rst_n_b = 1'b1;
    #1;
    checks++;
    if (b.mem_rd_en !== 1'b1 || b.mem_addr !== 16'h0100) begin
      errors++; $display("FAIL rst_midfetch_refetch: rd_en=%b addr=%h required 1 0100", b.mem_rd_en, b.mem_addr);
    end
    lat = 0;
    while (!b.ins_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || b.ins_pc !== 16'h0100 || b.ins_imm !== 16'h1234 || b.ins_len !== 2'd3) begin
      errors++; $display("FAIL rst_midfetch_insn: lat=%0d pc=%h imm=%h len=%0d required 4 0100 1234 3",
                         lat, b.ins_pc, b.ins_imm, b.ins_len);
    end
  endtask

  task automatic test_random_stream();
    int          lat;
    int          exp_len;
    logic [15:0] exp_pc;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [7:0]  op;
    logic [15:0] exp_imm;
    clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    reset_a();
    exp_pc = 16'h0000;
    for (int k = 0; k < 150; k++) begin
      op = mem[exp_pc];
      p1 = exp_pc + 16'd1;
      p2 = exp_pc + 16'd2;
      exp_len = len_tbl[op];
      exp_imm = (exp_len == 3) ? {mem[p2], mem[p1]} : (exp_len == 2) ? {8'h00, mem[p1]} : 16'h0000;
      wait_valid_a(lat);
      checks++;
      if (lat != exp_len + 1) begin
        errors++; $display("FAIL rnd_latency: insn %0d pc=%h op=%h got %0d required %0d",
                           k, exp_pc, op, lat, exp_len + 1);
      end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (a.ins_valid !== 1'b1 || a.ins_opcode !== op || a.ins_pc !== exp_pc ||
          a.ins_len !== 2'(exp_len) || a.ins_imm !== exp_imm) begin
        errors++; $display("FAIL rnd_insn: insn %0d got v=%b op=%h pc=%h len=%0d imm=%h required 1 %h %h %0d %h",
                           k, a.ins_valid, a.ins_opcode, a.ins_pc, a.ins_len, a.ins_imm,
                           op, exp_pc, exp_len, exp_imm);
      end
      a.ins_ready = 1'b1;
      tick();
      a.ins_ready = 1'b0;
      exp_pc = exp_pc + 16'(exp_len);
      checks++;
      if (a.halted !== (op == 8'h76) || a.ins_valid !== 1'b0) begin
        errors++; $display("FAIL rnd_after_hs: insn %0d op=%h halted=%b valid=%b required %b 0",
                           k, op, a.halted, a.ins_valid, (op == 8'h76));
      end
      if (op == 8'h76) begin
        repeat ($urandom_range(0, 3)) tick();
        a.resume = 1'b1;
        tick();
        a.resume = 1'b0;
        #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    a.ins_ready = 1'b0; a.redirect = 1'b0; a.redirect_pc = 16'h0; a.resume = 1'b0;
    b.ins_ready = 1'b0; b.redirect = 1'b0; b.redirect_pc = 16'h0; b.resume = 1'b0;
    build_len_tbl();
    clear_mem();
    test_reset();
    test_all_zero();
    test_mvi();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_midfetch();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
